// File: rtl/mcp3208_wrap.sv
// Autonomous MCP3208 scanner: walks the enabled channels over SPI and keeps the latest code per channel.
// Optional MCP3208_AVG_EN: each store update averages the new sample with the previous code.
module mcp3208_wrap #(
  parameter logic [6:0] BASE_ADDR   = 7'd0,
  parameter logic [7:0] DIV_DEFAULT = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lb_data,
  input  logic [6:0]  lb_addr,
  input  logic        lb_write,
  input  logic [3:0]  address,
  output logic [7:0]  result,
  output logic        adc_cs,
  output logic        adc_clk,
  input  logic        adc_dout,
  output logic        adc_din
);

  // state | meaning
  // GAP   | cs high for 4 ticks, then pick the next enabled channel
  // SETUP | cs low, start bit presented, 1 tick
  // XFER  | 19 SCLK cycles (high tick, low tick); B11..B0 on cycles 8..19
  typedef enum logic [1:0] {ST_GAP, ST_SETUP, ST_XFER} state_t;

  logic [7:0]  div_q, div_d, ena_q, ena_d, cnt_q, cnt_d, div_eff, result_q, result_d;
  logic        run_q, run_d, sgl_q, sgl_d, tick;
  state_t      state_q, state_d;
  logic [5:0]  ph_q, ph_d;
  logic [2:0]  ptr_q, ptr_d, ptr_nxt;
  logic [11:0] shift_q, shift_d;
  logic [11:0] code_q [8];
  logic [11:0] code_d [8];
  logic        cs_q, cs_d, sclk_q, sclk_d, din_q, din_d;
  logic [4:0]  bit_idx;
  logic        unused_lb_data;
`ifdef MCP3208_AVG_EN
  logic [7:0]  seen_q, seen_d;
  logic [12:0] avg_sum;
`endif

  assign unused_lb_data = ^lb_data[31:8];

  function automatic logic din_bit(input logic [4:0] idx, input logic sgl, input logic [2:0] ch);
    case (idx)
      5'd1:    din_bit = 1'b1;
      5'd2:    din_bit = sgl;
      5'd3:    din_bit = ch[2];
      5'd4:    din_bit = ch[1];
      5'd5:    din_bit = ch[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    div_d = div_q;
    ena_d = ena_q;
    run_d = run_q;
    sgl_d = sgl_q;
    if (lb_write) begin
      if (lb_addr == BASE_ADDR) begin
        div_d = lb_data[7:0];
      end else if (lb_addr == BASE_ADDR + 7'd1) begin
        ena_d = lb_data[7:0];
      end else if (lb_addr == BASE_ADDR + 7'd2) begin
        run_d = lb_data[0];
        sgl_d = lb_data[1];
      end
    end
  end

  // The running tick count finishes with the old DIV; a new DIV is only picked up on reload.
  assign div_eff = (div_q == 8'd0) ? 8'd1 : div_q;
  assign tick    = (cnt_q == 8'd0);
  assign cnt_d   = tick ? (div_eff - 8'd1) : (cnt_q - 8'd1);

  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 8; i >= 1; i--) begin
      if (ena_q[3'(ptr_q + 3'(i))]) ptr_nxt = 3'(ptr_q + 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    ptr_d   = ptr_q;
    shift_d = shift_q;
    code_d  = code_q;
`ifdef MCP3208_AVG_EN
    seen_d  = seen_q;
    avg_sum = {1'b0, code_q[ptr_q]} + {1'b0, shift_q} + 13'd1;
`endif
    if (tick) begin
      case (state_q)
        ST_GAP: begin
          if (ph_q != 6'd3) begin
            ph_d = ph_q + 6'd1;
          end else if (run_q && ena_q != 8'd0) begin
            ptr_d   = ptr_nxt;
            state_d = ST_SETUP;
            ph_d    = 6'd0;
          end
        end
        ST_SETUP: begin
          state_d = ST_XFER;
          ph_d    = 6'd0;
        end
        ST_XFER: begin
          if (ph_q == 6'd37) begin
            state_d = ST_GAP;
            ph_d    = 6'd0;
`ifdef MCP3208_AVG_EN
            code_d[ptr_q] = seen_q[ptr_q] ? avg_sum[12:1] : shift_q;
            seen_d[ptr_q] = 1'b1;
`else
            code_d[ptr_q] = shift_q;
`endif
          end else begin
            ph_d = ph_q + 6'd1;
            // odd ph -> even ph is an SCLK rising edge; cycles 8..19 carry data
            if (ph_q[0] && ph_q >= 6'd13) shift_d = {shift_q[10:0], adc_dout};
          end
        end
        default: begin
          state_d = ST_GAP;
          ph_d    = 6'd0;
        end
      endcase
    end
  end

  // Pins only move on a tick, so DIN is frozen for the whole high phase.
  always_comb begin
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    bit_idx = 5'(ph_d[5:1]) + 5'd1 + 5'(ph_d[0]);
    if (tick) begin
      case (state_d)
        ST_SETUP: begin
          cs_d   = 1'b0;
          sclk_d = 1'b0;
          din_d  = 1'b1;
        end
        ST_XFER: begin
          cs_d   = 1'b0;
          sclk_d = ~ph_d[0];
          din_d  = din_bit(bit_idx, sgl_q, ptr_d);
        end
        default: begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          din_d  = 1'b0;
        end
      endcase
    end
  end

  assign result_d = address[0] ? {4'b0, code_q[address[3:1]][11:8]} : code_q[address[3:1]][7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_DEFAULT;
      ena_q    <= 8'hFF;
      run_q    <= 1'b1;
      sgl_q    <= 1'b1;
      cnt_q    <= (DIV_DEFAULT == 8'd0) ? 8'd0 : (DIV_DEFAULT - 8'd1);
      state_q  <= ST_GAP;
      ph_q     <= 6'd0;
      ptr_q    <= 3'd0;
      shift_q  <= 12'd0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      din_q    <= 1'b0;
      result_q <= 8'd0;
      for (int i = 0; i < 8; i++) code_q[i] <= 12'd0;
`ifdef MCP3208_AVG_EN
      seen_q   <= 8'd0;
`endif
    end else begin
      div_q    <= div_d;
      ena_q    <= ena_d;
      run_q    <= run_d;
      sgl_q    <= sgl_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ph_q     <= ph_d;
      ptr_q    <= ptr_d;
      shift_q  <= shift_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      result_q <= result_d;
      code_q   <= code_d;
`ifdef MCP3208_AVG_EN
      seen_q   <= seen_d;
`endif
    end
  end

  assign result  = result_q;
  assign adc_cs  = cs_q;
  assign adc_clk = sclk_q;
  assign adc_din = din_q;

endmodule

// File: tb/tb_mcp3208_wrap.sv
// Bench for mcp3208_wrap: behavioural MCP3208 on the pins plus a frame/channel/readback model.
module tb_mcp3208_wrap;

  localparam logic [6:0] BASE = 7'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lb_data;
  logic [6:0]  lb_addr;
  logic        lb_write;
  logic [3:0]  address;
  logic [7:0]  result;
  logic        adc_cs, adc_clk, adc_dout, adc_din;

  mcp3208_wrap #(.BASE_ADDR(BASE), .DIV_DEFAULT(8'd4)) dut (
    .clk(clk), .rst_n(rst_n), .lb_data(lb_data), .lb_addr(lb_addr), .lb_write(lb_write),
    .address(address), .result(result), .adc_cs(adc_cs), .adc_clk(adc_clk),
    .adc_dout(adc_dout), .adc_din(adc_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // register model, owned by the main process
  int         div_m;
  logic [7:0] ena_m;
  logic       run_m, sgl_m, div_chg;
  logic [7:0] snap_ena;
  logic       snap_run, snap_sgl;

  // ADC and store model, owned by the monitor
  logic [11:0] adc_val  [8];
  logic [11:0] exp_code [8];
  logic [7:0]  seen_m;
  logic        rerand;
  int          frames, last_fall, period_last, pred_ptr, pred, rises, low_cnt, hi_cnt, frame_div;
  logic        in_frame, prev_cs, prev_sclk, clean, din_hold, din_bad, sgl_exp;
  logic [4:0]  bits, last_bits;
  logic [11:0] frame_val;

  function automatic int eff_div(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int next_en(input int p, input logic [7:0] e);
    for (int i = 1; i <= 8; i++) if (e[(p + i) % 8]) return (p + i) % 8;
    return p;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; prev_cs = 1; prev_sclk = 0; adc_dout = 0; pred_ptr = 0;
      last_fall = -1; seen_m = 8'd0;
      for (int i = 0; i < 8; i++) exp_code[i] = 12'd0;
    end else begin
      if (prev_cs && !adc_cs) begin
        in_frame = 1; low_cnt = 0; hi_cnt = 0; rises = 0; bits = 0; din_bad = 0;
        clean = !div_chg; div_chg = 0; frame_div = eff_div(div_m);
        check_val("run_at_start", int'(snap_run), 1);
        pred = next_en(pred_ptr, snap_ena);
        pred_ptr = pred;
        frames++;
        if (last_fall >= 0) period_last = cyc - last_fall;
        last_fall = cyc;
      end
      if (!adc_cs && in_frame) begin
        low_cnt++;
        if (adc_clk) hi_cnt++;
        if (!prev_sclk && adc_clk) begin
          rises++;
          if (rises <= 5) bits = {bits[3:0], adc_din};
          if (rises == 5) frame_val = adc_val[bits[2:0]];
          din_hold = adc_din;
        end else if (adc_clk && adc_din != din_hold) begin
          din_bad = 1;
        end
        if (prev_sclk && !adc_clk) begin
          if (rises == 1) sgl_exp = snap_sgl;
          if (rises >= 7 && rises <= 18) adc_dout = frame_val[18 - rises];
          else adc_dout = 1'b0;
        end
      end
      if (!prev_cs && adc_cs && in_frame) begin
        in_frame = 0;
        last_bits = bits;
        check_val("sclk_rises", rises, 19);
        check_val("start_bit", int'(bits[4]), 1);
        check_val("sgl_bit", int'(bits[3]), int'(sgl_exp));
        check_val("channel", int'(bits[2:0]), pred);
        check_val("din_stable_high", int'(din_bad), 0);
        if (clean && !div_chg) begin
          check_val("cs_low_clks", low_cnt, 39 * frame_div);
          check_val("sclk_high_clks", hi_cnt, 19 * frame_div);
        end
`ifdef MCP3208_AVG_EN
        exp_code[pred] = seen_m[pred] ? 12'((13'(exp_code[pred]) + 13'(frame_val) + 13'd1) >> 1) : frame_val;
`else
        exp_code[pred] = frame_val;
`endif
        seen_m[pred] = 1'b1;
        if (rerand) adc_val[bits[2:0]] = 12'($urandom);
      end
      prev_cs = adc_cs; prev_sclk = adc_clk;
    end
    snap_ena = ena_m; snap_run = run_m; snap_sgl = sgl_m;
  end

  task automatic model_defaults();
    div_m = 4; ena_m = 8'hFF; run_m = 1; sgl_m = 1; div_chg = 0;
  endtask

  task automatic reg_wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    lb_addr = a; lb_data = d; lb_write = 1'b1;
    @(posedge clk);
    #1 lb_write = 1'b0;
    if (a == BASE) begin div_m = int'(d[7:0]); div_chg = 1; end
    else if (a == BASE + 7'd1) ena_m = d[7:0];
    else if (a == BASE + 7'd2) begin run_m = d[0]; sgl_m = d[1]; end
  endtask

  task automatic wait_frames(input int n);
    int target, budget;
    target = frames + n;
    budget = (n + 2) * 50 * eff_div(div_m) + 100;
    for (int i = 0; i < budget && frames < target; i++) @(posedge clk);
    check_val("frames_reached", int'(frames >= target), 1);
  endtask

  task automatic read_byte(input int a, output logic [7:0] v);
    @(negedge clk) address = 4'(a);
    @(negedge clk) v = result;
  endtask

  task automatic readback_all(input string tag);
    logic [7:0] v, e;
    for (int a = 0; a < 16; a++) begin
      read_byte(a, v);
      e = a[0] ? {4'b0, exp_code[a / 2][11:8]} : exp_code[a / 2][7:0];
      check_val(tag, int'(v), int'(e));
    end
  endtask

  task automatic stop_scan();
    reg_wr(BASE + 7'd2, {30'd0, sgl_m, 1'b0});
    repeat (45 * eff_div(div_m) + 5) @(posedge clk);
    check_val("stopped_cs_high", int'(adc_cs), 1);
    repeat (2 * eff_div(div_m)) @(negedge clk);
    check_val("stopped_cs_stays", int'(adc_cs), 1);
  endtask

  initial begin
    logic [7:0] v;
    int f0, d;
    logic [7:0] e;
    logic s;
    lb_data = 0; lb_addr = 0; lb_write = 0; address = 0; rerand = 0; frames = 0; period_last = 0;
    for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
    adc_val[3] = 12'hA5C;
    model_defaults();
    rst_n = 0;
    #12;
    check_val("rst_cs", int'(adc_cs), 1);
    check_val("rst_sclk", int'(adc_clk), 0);
    check_val("rst_din", int'(adc_din), 0);
    check_val("rst_result", int'(result), 0);
    @(negedge clk) rst_n = 1;

    // default scan: one pass over all eight channels
    wait_frames(8);
    stop_scan();
    read_byte(6, v); check_val("ch3_lo", int'(v), 8'h5C);
    read_byte(7, v); check_val("ch3_hi", int'(v), 8'h0A);
    readback_all("readback_default");
    rerand = 1;

    // single channel, then resume check
    reg_wr(BASE + 7'd1, 32'h04);
    reg_wr(BASE + 7'd2, 32'h3);
    wait_frames(3);
    check_val("ena04_din_bits", int'(last_bits), 5'b11010);
    check_val("ena04_period", period_last, 172);

    reg_wr(BASE + 7'd0, 32'd10);
    wait_frames(3);
    check_val("div10_period", period_last, 430);
    stop_scan();
    readback_all("readback_div10");
    reg_wr(BASE + 7'd2, 32'h3);

    reg_wr(BASE + 7'd0, 32'd4);
    reg_wr(BASE + 7'd1, 32'hFF);
    reg_wr(BASE + 7'd2, 32'h1);
    wait_frames(3);
    check_val("diff_din_sgl", int'(last_bits[3]), 0);

    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 6);
      e = (it == 3) ? 8'h00 : 8'($urandom_range(1, 255));
      s = 1'($urandom_range(0, 1));
      reg_wr(BASE + 7'd0, 32'(d));
      reg_wr(BASE + 7'd1, {24'd0, e});
      reg_wr(BASE + 7'd2, {30'd0, s, 1'b1});
      if (e == 8'h00) begin
        repeat (50 * eff_div(d)) @(posedge clk);
        f0 = frames;
        repeat (100 * eff_div(d)) @(posedge clk);
        check_val("ena0_idle", frames, f0);
      end else begin
        wait_frames(3);
        check_val("rand_period", period_last, 43 * eff_div(d));
        stop_scan();
        readback_all("readback_rand");
      end
    end

    // reset in the middle of a transfer
    reg_wr(BASE + 7'd2, 32'h3);
    for (int i = 0; i < 3000 && !(in_frame && rises >= 3); i++) @(posedge clk);
    check_val("reached_xfer", int'(in_frame && rises >= 3), 1);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check_val("abort_cs_async", int'(adc_cs), 1);
    model_defaults();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    readback_all("readback_after_rst");

    reg_wr(BASE + 7'd3, 32'h0);
    reg_wr(7'($urandom_range(3, 127)), 32'h0);
    wait_frames(3);
    check_val("unmatched_period", period_last, 172);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
